// File: rtl/uart_tx_feeder.sv
// Buffers received bytes in a circular FIFO and launches them one at a time into the UART transmitter.
// Push visible in o_count one edge after the strobe; launch one edge later; the next launch waits for i_tx_done.
module uart_tx_feeder #(
    parameter int ADDR_W = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rx_interrupt,
    input  logic [7:0]        i_rx_data,
    input  logic              i_tx_done,
    output logic              o_tx_data_interrupt,
    output logic [7:0]        o_tx_data,
    output logic [ADDR_W:0]   o_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_int_q, tx_int_d;
    logic                full_w, empty_w;
    logic                push, pop;

    assign full_w  = (count_q == FULL_CNT);
    assign empty_w = (count_q == '0);

    // Full is judged on the registered count, so a pop in the same cycle does not rescue the push.
    assign push = i_rx_interrupt && !full_w;

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        tx_data_d = tx_data_q;
        tx_int_d  = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_w) begin
                    pop       = 1'b1;
                    tx_data_d = mem[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
                    tx_int_d  = 1'b1;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (i_tx_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = push ? (wr_ptr_q + ADDR_W'(1)) : wr_ptr_q;
        overflow_d = overflow_q | (i_rx_interrupt & full_w);
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_int_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
            tx_int_q   <= tx_int_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[wr_ptr_q] <= i_rx_data;
        end
    end

    assign o_tx_data_interrupt = tx_int_q;
    assign o_tx_data           = tx_data_q;
    assign o_count             = count_q;
    assign o_empty             = empty_w;
    assign o_full              = full_w;
    assign o_overflow          = overflow_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a byte scoreboard checked on every launch strobe.
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_rx_interrupt = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_tx_done = 1'b0;
    logic       o_tx_data_interrupt;
    logic [7:0] o_tx_data;
    logic [4:0] o_count;
    logic       o_empty;
    logic       o_full;
    logic       o_overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobes = 0;
    int last_strobe_cyc = 0;
    int last_gap = 0;
    bit have_last = 1'b0;
    int base;
    logic [7:0] exp_q[$];

    uart_tx_feeder #(.ADDR_W(4)) dut (
        .i_clock             (clk),
        .i_reset             (i_reset),
        .i_rx_interrupt      (i_rx_interrupt),
        .i_rx_data           (i_rx_data),
        .i_tx_done           (i_tx_done),
        .o_tx_data_interrupt (o_tx_data_interrupt),
        .o_tx_data           (o_tx_data),
        .o_count             (o_count),
        .o_empty             (o_empty),
        .o_full              (o_full),
        .o_overflow          (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then inspect any launch strobe against the scoreboard.
    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (o_tx_data_interrupt === 1'b1) begin
            strobes++;
            if (have_last) begin
                last_gap = cyc - last_strobe_cyc;
                chk("strobe_spacing_min", 32'(last_gap >= 3), 32'(1));
            end
            last_strobe_cyc = cyc;
            have_last = 1'b1;
            chk("strobe_expected_pending", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("tx_data_order", 32'(o_tx_data), 32'(e));
            end
        end
    endtask

    task automatic push(input logic [7:0] b, input bit accept);
        i_rx_interrupt = 1'b1;
        i_rx_data = b;
        if (accept) exp_q.push_back(b);
        tick();
        i_rx_interrupt = 1'b0;
    endtask

    // Pulse i_tx_done so it is sampled gap+1 edges after the last launch.
    task automatic answer(input int gap);
        while (cyc < last_strobe_cyc + gap) tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    task automatic wait_strobes(input int target);
        int n = 0;
        while (strobes < target && n < 200) begin
            tick();
            n++;
        end
        chk("strobe_arrived", 32'(strobes >= target), 32'(1));
    endtask

    initial begin
        // Reset then idle
        tick();
        tick();
        chk("rst_empty", 32'(o_empty), 32'(1));
        chk("rst_count", 32'(o_count), 32'(0));
        chk("rst_full", 32'(o_full), 32'(0));
        chk("rst_overflow", 32'(o_overflow), 32'(0));
        chk("rst_strobe", 32'(o_tx_data_interrupt), 32'(0));
        chk("rst_tx_data", 32'(o_tx_data), 32'(8'h00));
        i_reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("idle_no_strobe", 32'(strobes), 32'(0));
        chk("idle_empty", 32'(o_empty), 32'(1));

        // Single byte
        push(8'hA5, 1'b1);
        chk("single_count_after_push", 32'(o_count), 32'(1));
        chk("single_not_empty", 32'(o_empty), 32'(0));
        chk("single_no_early_strobe", 32'(o_tx_data_interrupt), 32'(0));
        tick();
        chk("single_strobe", 32'(o_tx_data_interrupt), 32'(1));
        chk("single_data", 32'(o_tx_data), 32'(8'hA5));
        chk("single_count_after_pop", 32'(o_count), 32'(0));
        tick();
        chk("single_strobe_one_cycle", 32'(o_tx_data_interrupt), 32'(0));
        chk("single_data_held", 32'(o_tx_data), 32'(8'hA5));
        answer(20);
        for (int i = 0; i < 30; i++) tick();
        chk("single_no_extra_strobe", 32'(strobes), 32'(1));

        // Burst ordering with 12-cycle launch spacing
        base = strobes;
        for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
        for (int i = 0; i < 5; i++) begin
            wait_strobes(base + i + 1);
            if (i > 0) chk("burst_spacing", 32'(last_gap), 32'(12));
            answer(10);
        end
        for (int i = 0; i < 5; i++) tick();
        chk("burst_end_empty", 32'(o_empty), 32'(1));
        chk("burst_queue_drained", 32'(exp_q.size()), 32'(0));

        // Full, overflow and pointer wrap
        base = strobes;
        for (int i = 0; i < 18; i++) begin
            push(8'(8'h10 + i), i < 17);
            if (i == 16) begin
                chk("fill_full", 32'(o_full), 32'(1));
                chk("fill_count", 32'(o_count), 32'(16));
                chk("fill_no_overflow_yet", 32'(o_overflow), 32'(0));
            end
        end
        chk("drop_overflow", 32'(o_overflow), 32'(1));
        chk("drop_count", 32'(o_count), 32'(16));
        chk("drop_full", 32'(o_full), 32'(1));
        for (int i = 0; i < 5; i++) tick();
        chk("overflow_sticky", 32'(o_overflow), 32'(1));
        for (int i = 0; i < 16; i++) begin
            answer(3);
            wait_strobes(base + 2 + i);
        end
        answer(3);
        tick();
        chk("drain_empty", 32'(o_empty), 32'(1));
        chk("drain_overflow_kept", 32'(o_overflow), 32'(1));
        chk("drain_queue_drained", 32'(exp_q.size()), 32'(0));

        // Simultaneous push and pop with three stored bytes
        base = strobes;
        push(8'hA1, 1'b1);
        push(8'hB1, 1'b1);
        push(8'hB2, 1'b1);
        push(8'hB3, 1'b1);
        chk("simul_pre_count", 32'(o_count), 32'(3));
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        chk("simul_idle_count", 32'(o_count), 32'(3));
        push(8'hB4, 1'b1);
        chk("simul_strobe", 32'(o_tx_data_interrupt), 32'(1));
        chk("simul_count_kept", 32'(o_count), 32'(3));
        for (int i = 0; i < 3; i++) begin
            answer(3);
            wait_strobes(base + 3 + i);
        end
        answer(3);
        tick();
        chk("simul_end_empty", 32'(o_empty), 32'(1));
        chk("simul_queue_drained", 32'(exp_q.size()), 32'(0));

        // Reset in S_WAIT with four stored bytes
        push(8'hC0, 1'b1);
        for (int i = 1; i <= 4; i++) push(8'(8'hC0 + i), 1'b1);
        chk("midrst_pre_count", 32'(o_count), 32'(4));
        i_reset = 1'b1;
        tick();
        exp_q.delete();
        chk("midrst_count", 32'(o_count), 32'(0));
        chk("midrst_empty", 32'(o_empty), 32'(1));
        chk("midrst_full", 32'(o_full), 32'(0));
        chk("midrst_overflow", 32'(o_overflow), 32'(0));
        chk("midrst_strobe", 32'(o_tx_data_interrupt), 32'(0));
        chk("midrst_tx_data", 32'(o_tx_data), 32'(8'h00));
        i_reset = 1'b0;
        push(8'h3C, 1'b1);
        chk("post_rst_count", 32'(o_count), 32'(1));
        tick();
        chk("post_rst_strobe", 32'(o_tx_data_interrupt), 32'(1));
        chk("post_rst_data", 32'(o_tx_data), 32'(8'h3C));
        answer(5);
        for (int i = 0; i < 5; i++) tick();
        chk("post_rst_empty", 32'(o_empty), 32'(1));
        chk("post_rst_queue_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
